// File: rtl/alu_pipelined_if.sv
// alu_pipelined_if
//   Handshake bundle between the ALU and its producer/consumer.
//   Ports (slave = ALU side):
//     in_valid  / in_ready   op handshake, producer -> ALU
//     a, b      [N-1:0]      operands
//     control   [3:0]        operation code
//     out_valid / out_ready  result handshake, ALU -> consumer
//     result    [N-1:0]      operation result
//     overflow, zero, equal  result flags
//   The master modport is the producer/consumer side (CPU datapath or bench).

interface alu_pipelined_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   control;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         overflow;
    logic         zero;
    logic         equal;

    modport master (
        output in_valid, a, b, control, out_ready,
        input  in_ready, out_valid, result, overflow, zero, equal
    );

    modport slave (
        input  in_valid, a, b, control, out_ready,
        output in_ready, out_valid, result, overflow, zero, equal
    );
endinterface

// File: rtl/alu_pipelined.sv
// alu_pipelined
//   Registered, handshaked ALU for the multicycle CPU datapath. One op is
//   taken per in_valid/in_ready transaction; result and flags are returned
//   on out_valid/out_ready and held stable until the consumer takes them.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-low reset
//     bus   alu_pipelined_if.slave (op handshake, operands, result, flags)
//   Optional feature macro: ALU_MUL_EN
//     defined   -> code 11 (MUL) runs an N-iteration radix-2 shift-add
//     undefined -> no multiplier is built; code 11 behaves as an unknown code
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no result pending, ready for a new op
//   BUSY  | multiply iterating (only reachable with ALU_MUL_EN)
//   DONE  | result/flags presented, held until out_ready

module alu_pipelined #(
    parameter int N = 32
) (
    input logic            clk,
    input logic            rst,
    alu_pipelined_if.slave bus
);
    localparam int SHAMT_W = $clog2(N);

    typedef enum logic [3:0] {
        ALU_AND  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_SLL  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_SRA  = 4'd6,
        ALU_ADD  = 4'd7,
        ALU_SUB  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10,
        ALU_MUL  = 4'd11
    } alu_control_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         accept;
    logic         start_mul;
    logic [N-1:0] sc_result;
    logic         sc_overflow;
    logic [N-1:0] sum;
    logic [N-1:0] diff;
    logic [SHAMT_W-1:0] shamt;

    logic [N-1:0] result_q;
    logic         overflow_q;
    logic         zero_q;
    logic         equal_q;

    // in_ready follows out_ready combinationally in DONE so a consumer that
    // keeps out_ready high sees one single-cycle op per clock. Gating with
    // rst keeps the port quiet while reset is asserted.
    assign bus.in_ready  = rst & ((state == ST_IDLE) |
                                  ((state == ST_DONE) & bus.out_ready));
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.equal     = equal_q;

    assign sum   = bus.a + bus.b;
    assign diff  = bus.a - bus.b;
    assign shamt = bus.b[SHAMT_W-1:0];

    // Single-cycle datapath, evaluated on the live operands and captured
    // at the accept edge.
    always_comb begin
        sc_result   = '0;
        sc_overflow = 1'b0;
        start_mul   = 1'b0;
        case (bus.control)
            ALU_AND:  sc_result = bus.a & bus.b;
            ALU_OR:   sc_result = bus.a | bus.b;
            ALU_XOR:  sc_result = bus.a ^ bus.b;
            ALU_SLL:  sc_result = bus.a << shamt;
            ALU_SRL:  sc_result = bus.a >> shamt;
            ALU_SRA:  sc_result = $signed(bus.a) >>> shamt;
            ALU_ADD: begin
                sc_result   = sum;
                sc_overflow = (bus.a[N-1] == bus.b[N-1]) && (sum[N-1] != bus.a[N-1]);
            end
            ALU_SUB: begin
                sc_result   = diff;
                sc_overflow = (bus.a[N-1] != bus.b[N-1]) && (diff[N-1] != bus.a[N-1]);
            end
            ALU_SLT:  sc_result = {{(N-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            ALU_SLTU: sc_result = {{(N-1){1'b0}}, (bus.a < bus.b)};
            ALU_MUL: begin
`ifdef ALU_MUL_EN
                start_mul = 1'b1;
`endif
            end
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(N) + 1;

    logic [CNT_W-1:0] mul_cnt;
    logic [N-1:0]     mcand;
    logic [N-1:0]     p_hi;
    logic [N-1:0]     p_lo;
    logic [N:0]       hi_sum;
    logic             mul_last;

    // The counter walks 0..N-1 over the N iterations; the cycle with
    // mul_cnt == N loads the finished product into the output registers.
    assign mul_last = (mul_cnt == CNT_W'(N));
    // p_lo starts as the multiplier and shifts right, so its LSB is the
    // multiplier bit for the current iteration.
    assign hi_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : {(N+1){1'b0}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_cnt <= '0;
            mcand   <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
        end else if (accept && start_mul) begin
            mul_cnt <= '0;
            mcand   <= bus.a;
            p_hi    <= '0;
            p_lo    <= bus.b;
        end else if ((state == ST_BUSY) && !mul_last) begin
            {p_hi, p_lo} <= {hi_sum, p_lo[N-1:1]};
            mul_cnt      <= mul_cnt + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = start_mul ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
`ifdef ALU_MUL_EN
                if (mul_last) state_nxt = ST_DONE;
`else
                state_nxt = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (accept)             state_nxt = start_mul ? ST_BUSY : ST_DONE;
                else if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output registers only change on accept or multiply completion, which
    // is what keeps them stable while DONE waits on out_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            equal_q    <= 1'b0;
        end else if (accept) begin
            equal_q <= (bus.a == bus.b);
            if (!start_mul) begin
                result_q   <= sc_result;
                overflow_q <= sc_overflow;
                zero_q     <= (sc_result == '0);
            end
        end
`ifdef ALU_MUL_EN
        else if ((state == ST_BUSY) && mul_last) begin
            result_q   <= p_lo;
            overflow_q <= |p_hi;
            zero_q     <= (p_lo == '0);
        end
`endif
    end
endmodule

// File: tb/tb_alu_pipelined.sv
// tb_alu_pipelined
//   Scoreboard bench for alu_pipelined (N=32). The driver pushes the expected
//   response from a behavioural model at each accept; a negedge monitor
//   compares every presented result against the queue head and pops on the
//   output handshake. Works with or without ALU_MUL_EN.

module tb_alu_pipelined;
    localparam int N = 32;

    typedef struct {
        logic [N-1:0] result;
        logic         ovf;
        logic         zero;
        logic         eq;
        int           lat;
        int           acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];
    bit   fresh = 1'b1;
    bit   rand_ready = 1'b0;
    bit   ready_fixed = 1'b1;
    int   last_acc = 0;

    alu_pipelined_if #(.N(N)) bus ();

    alu_pipelined #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sole driver of out_ready; changes only just after the rising edge.
    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t   e;
        longint sa, sbv, r;
        logic [63:0] p;
        int     sh;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        sh  = int'(b % N);
        e.result = '0;
        e.ovf    = 1'b0;
        e.lat    = 1;
        e.acc_cyc = 0;
        case (op)
            4'd1:  e.result = a & b;
            4'd2:  e.result = a | b;
            4'd3:  e.result = a ^ b;
            4'd4:  e.result = a << sh;
            4'd5:  e.result = a >> sh;
            4'd6:  e.result = N'(sa >>> sh);
            4'd7: begin
                r = sa + sbv;
                e.result = N'(r);
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'd8: begin
                r = sa - sbv;
                e.result = N'(r);
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'd9:  e.result = (sa < sbv) ? 1 : 0;
            4'd10: e.result = (a < b) ? 1 : 0;
`ifdef ALU_MUL_EN
            4'd11: begin
                p = 64'(a) * 64'(b);
                e.result = p[N-1:0];
                e.ovf = (p[63:N] != 0);
                e.lat = N + 1;
            end
`endif
            default: e.result = '0;
        endcase
        e.zero = (e.result == 0);
        e.eq   = (a == b);
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int   guard = 0;
        bus.in_valid = 1'b1;
        bus.control  = op;
        bus.a        = a;
        bus.b        = b;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            chk("issue_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        e = model(op, a, b);
        e.acc_cyc = cyc;
        last_acc  = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.control  = 4'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 64'(bus.out_valid), 64'd0);
            end else begin
                e = sb[0];
                chk("result",   64'(bus.result),   64'(e.result));
                chk("overflow", 64'(bus.overflow), 64'(e.ovf));
                chk("zero",     64'(bus.zero),     64'(e.zero));
                chk("equal",    64'(bus.equal),    64'(e.eq));
                if (fresh) begin
                    chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                    fresh = 1'b0;
                end
                if (bus.out_ready) begin
                    void'(sb.pop_front());
                    fresh = 1'b1;
                end
            end
        end
    end

    function automatic logic [N-1:0] pick_operand();
        logic [N-1:0] specials [5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'h7FFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) == 0) return N'($urandom_range(0, 40));
        return $urandom;
    endfunction

    initial begin
        int first_acc;
        logic [N-1:0] ra, rb;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.control  = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_result",    64'(bus.result),    64'd0);
        chk("rst_overflow",  64'(bus.overflow),  64'd0);
        chk("rst_zero",      64'(bus.zero),      64'd0);
        chk("rst_equal",     64'(bus.equal),     64'd0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed cases
        issue(4'd7,  32'h7FFF_FFFF, 32'd1);
        issue(4'd6,  32'h8000_0000, 32'd4);
        issue(4'd4,  32'd1,         32'd35);
        issue(4'd8,  32'd5,         32'd5);
        issue(4'd9,  32'hFFFF_FFFF, 32'd1);
        issue(4'd10, 32'hFFFF_FFFF, 32'd1);
        issue(4'd0,  32'd3,         32'd3);
        issue(4'd15, 32'd9,         32'd2);
        drain();

        // Back-to-back stream: accepts on consecutive cycles
        issue(4'd7, 32'd1, 32'd2);
        first_acc = last_acc;
        issue(4'd7, 32'd3, 32'd4);
        issue(4'd7, 32'hFFFF_FFFF, 32'd1);
        issue(4'd7, 32'h8000_0000, 32'h8000_0000);
        chk("stream_consecutive", 64'(last_acc - first_acc), 64'd3);
        drain();

        // Backpressure: result held, in_ready low
        ready_fixed = 1'b0;
        @(posedge clk);
        #2;
        issue(4'd3, 32'hA5A5_0F0F, 32'h0F0F_A5A5);
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
        end
        ready_fixed = 1'b1;
        drain();

        // Multiply
        issue(4'd11, 32'h0001_0000, 32'h0001_0000);
        issue(4'd11, 32'd7, 32'd6);
        drain();

        // Reset in the middle of an op
        ready_fixed = 1'b0;
        @(posedge clk);
        #2;
        issue(4'd11, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_in_ready",  64'(bus.in_ready),  64'd0);
        sb.delete();
        fresh = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        ready_fixed = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        issue(4'd7, 32'd10, 32'd20);
        drain();

        // Randomized traffic with random consumer stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 250; i++) begin
            ra = pick_operand();
            rb = ($urandom_range(0, 4) == 0) ? ra : pick_operand();
            issue(4'($urandom_range(0, 15)), ra, rb);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        ready_fixed = 1'b1;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
